// File: rtl/btn_pulse_gen.sv
// btn_pulse_gen: per-channel push-button conditioning.
// Each of N channels synchronises one raw asynchronous button, debounces it, and produces a
// registered clean level plus one-cycle press, release and auto-repeat pulses.
//
// Ports:
//   clk_i      system clock, all state updates on the rising edge
//   rst_i      synchronous active-high reset
//   btn_in_i   raw asynchronous buttons, 1 = pressed
//   level_o    debounced button state
//   press_o    one-cycle pulse when a press is accepted
//   release_o  one-cycle pulse when a release is accepted
//   pulse_o    press OR auto-repeat pulse, intended as a register enable
module btn_pulse_gen #(
  parameter int unsigned N               = 3,
  parameter int unsigned SYNC_STAGES     = 2,         // minimum 2
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,   // minimum 1
  parameter int unsigned REPEAT_DELAY    = 0,         // 0 disables auto-repeat
  parameter int unsigned REPEAT_PERIOD   = 25000000   // minimum 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] btn_in_i,
  output logic [N-1:0] level_o,
  output logic [N-1:0] press_o,
  output logic [N-1:0] release_o,
  output logic [N-1:0] pulse_o
);

  localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RptW   = $clog2(RptMax + 1);

  localparam logic [DbW-1:0]  DbLast     = DbW'(DEBOUNCE_CYCLES - 1);
  // Only meaningful when auto-repeat is enabled; RepeatEn guards every use.
  localparam logic [RptW-1:0] DelayLast  = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] PeriodLast = RptW'(REPEAT_PERIOD - 1);
  localparam bit              RepeatEn   = (REPEAT_DELAY != 0);

  typedef enum logic [1:0] {
    StIdle,
    StHeld,
    StRepeat
  } state_e;

  // Synchroniser: index 0 captures the raw pins, index SYNC_STAGES-1 is the usable value.
  logic [SYNC_STAGES-1:0][N-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in_i};
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    state_e          state_q, state_d;
    logic [DbW-1:0]  db_cnt_q, db_cnt_d;
    logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic            s;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            pulse_q, pulse_d;
    logic            rpt_fire;

    assign s = sync_q[SYNC_STAGES-1][i];

    always_comb begin
      state_d   = state_q;
      db_cnt_d  = db_cnt_q;
      rpt_cnt_d = rpt_cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      rpt_fire  = 1'b0;

      // Debounce: a level change is accepted only after DEBOUNCE_CYCLES consecutive
      // mismatching samples; any sample agreeing with the level restarts the count.
      if (s == level_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == DbLast) begin
        db_cnt_d  = '0;
        level_d   = s;
        press_d   = s;
        release_d = ~s;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          rpt_cnt_d = '0;
          if (press_d) begin
            state_d = StHeld;
          end
        end
        StHeld: begin
          // Release is checked first so it wins over a coincident terminal count.
          if (release_d) begin
            state_d = StIdle;
          end else if (RepeatEn) begin
            if (rpt_cnt_q == DelayLast) begin
              state_d   = StRepeat;
              rpt_cnt_d = '0;
              rpt_fire  = 1'b1;
            end else begin
              rpt_cnt_d = rpt_cnt_q + 1'b1;
            end
          end
        end
        StRepeat: begin
          if (release_d) begin
            state_d = StIdle;
          end else if (rpt_cnt_q == PeriodLast) begin
            rpt_cnt_d = '0;
            rpt_fire  = 1'b1;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase

      pulse_d = press_d | rpt_fire;
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q   <= StIdle;
        db_cnt_q  <= '0;
        rpt_cnt_q <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        pulse_q   <= 1'b0;
      end else begin
        state_q   <= state_d;
        db_cnt_q  <= db_cnt_d;
        rpt_cnt_q <= rpt_cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        pulse_q   <= pulse_d;
      end
    end

    assign level_o[i]   = level_q;
    assign press_o[i]   = press_q;
    assign release_o[i] = release_q;
    assign pulse_o[i]   = pulse_q;
  end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// Testbench for btn_pulse_gen. Two instances share the stimulus: dut_a with auto-repeat
// (REPEAT_DELAY=10) and dut_b with auto-repeat disabled. A behavioural model feeds a
// scoreboard every cycle; table vectors and scripted sequences add hand-derived checks.
module tb_btn_pulse_gen;

  localparam int unsigned N  = 3;
  localparam int unsigned SS = 2;
  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;

  typedef struct packed {
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
    logic [N-1:0] pls;
  } outs_t;

  typedef struct {
    outs_t a;
    outs_t b;
  } sb_t;

  typedef struct {
    logic         rst;
    logic [N-1:0] btn;
    outs_t        exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn;
  logic [N-1:0] a_level, a_press, a_release, a_pulse;
  logic [N-1:0] b_level, b_press, b_release, b_pulse;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  sb_t sb_q[$];

  // Model state, indexed [instance][channel].
  bit    m_sy0 [2][N];
  bit    m_sy1 [2][N];
  bit    m_lvl [2][N];
  int    m_run [2][N];
  int    m_el  [2][N];
  outs_t m_exp [2];

  always #5 clk = ~clk;

  btn_pulse_gen #(
    .N              (N),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut_a (
    .clk_i    (clk),
    .rst_i    (rst),
    .btn_in_i (btn),
    .level_o  (a_level),
    .press_o  (a_press),
    .release_o(a_release),
    .pulse_o  (a_pulse)
  );

  btn_pulse_gen #(
    .N              (N),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (0),
    .REPEAT_PERIOD  (RP)
  ) dut_b (
    .clk_i    (clk),
    .rst_i    (rst),
    .btn_in_i (btn),
    .level_o  (b_level),
    .press_o  (b_press),
    .release_o(b_release),
    .pulse_o  (b_pulse)
  );

  task automatic chk(input string nm, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, got, exp);
    end
  endtask

  // Behavioural reference: level flips after DB consecutive synchronised samples that
  // disagree with it; repeats fire at RD edges after the press, then every RP edges.
  task automatic model_step(input logic r, input logic [N-1:0] b);
    for (int d = 0; d < 2; d++) begin
      int dly;
      dly = (d == 0) ? RD : 0;
      m_exp[d] = '0;
      for (int c = 0; c < N; c++) begin
        if (r) begin
          m_sy0[d][c] = 1'b0;
          m_sy1[d][c] = 1'b0;
          m_lvl[d][c] = 1'b0;
          m_run[d][c] = 0;
          m_el[d][c]  = 0;
        end else begin
          bit s, prs, rel, rpt;
          s   = m_sy1[d][c];
          prs = 1'b0;
          rel = 1'b0;
          rpt = 1'b0;
          m_sy1[d][c] = m_sy0[d][c];
          m_sy0[d][c] = b[c];
          if (s != m_lvl[d][c]) begin
            m_run[d][c]++;
            if (m_run[d][c] == DB) begin
              m_lvl[d][c] = s;
              m_run[d][c] = 0;
              m_el[d][c]  = 0;
              prs = s;
              rel = ~s;
            end
          end else begin
            m_run[d][c] = 0;
          end
          if (m_lvl[d][c] && !prs) begin
            m_el[d][c]++;
            if (dly != 0 && (m_el[d][c] == dly ||
                (m_el[d][c] > dly && ((m_el[d][c] - dly) % RP) == 0))) begin
              rpt = 1'b1;
            end
          end
          m_exp[d].lvl[c] = m_lvl[d][c];
          m_exp[d].prs[c] = prs;
          m_exp[d].rel[c] = rel;
          m_exp[d].pls[c] = prs | rpt;
        end
      end
    end
  endtask

  // One clock edge: drive inputs, queue the model's prediction, compare after the edge.
  task automatic step(input logic r, input logic [N-1:0] b);
    sb_t e;
    rst = r;
    btn = b;
    model_step(r, b);
    e.a = m_exp[0];
    e.b = m_exp[1];
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard cycle %0d: got empty queue expected one entry", cyc);
    end else begin
      e = sb_q.pop_front();
      chk("sb_a_level",   a_level,   e.a.lvl);
      chk("sb_a_press",   a_press,   e.a.prs);
      chk("sb_a_release", a_release, e.a.rel);
      chk("sb_a_pulse",   a_pulse,   e.a.pls);
      chk("sb_b_level",   b_level,   e.b.lvl);
      chk("sb_b_press",   b_press,   e.b.prs);
      chk("sb_b_release", b_release, e.b.rel);
      chk("sb_b_pulse",   b_pulse,   e.b.pls);
    end
  endtask

  initial begin
    vec_t vecs[$];
    outs_t z;
    outs_t p0;
    outs_t h0;
    outs_t p1;
    outs_t h1;
    z  = '0;
    p0 = '{lvl: 3'b001, prs: 3'b001, rel: 3'b000, pls: 3'b001};
    h0 = '{lvl: 3'b001, prs: 3'b000, rel: 3'b000, pls: 3'b000};
    p1 = '{lvl: 3'b010, prs: 3'b010, rel: 3'b000, pls: 3'b010};
    h1 = '{lvl: 3'b010, prs: 3'b000, rel: 3'b000, pls: 3'b000};

    rst = 1'b1;
    btn = '0;

    // Clean press on channel 0: accepted at edge 6 only.
    vecs.push_back('{1'b1, 3'b000, z});
    for (int e = 1; e <= 8; e++) begin
      vecs.push_back('{1'b0, 3'b001, (e < 6) ? z : ((e == 6) ? p0 : h0)});
    end
    vecs.push_back('{1'b1, 3'b001, z});
    // Glitch on channel 1 (3 cycles high) is rejected.
    for (int e = 1; e <= 3; e++) vecs.push_back('{1'b0, 3'b010, z});
    for (int e = 1; e <= 5; e++) vecs.push_back('{1'b0, 3'b000, z});
    // Bounce 1-0-1-1-1-1: press after the 4th consecutive synchronised high.
    vecs.push_back('{1'b0, 3'b010, z});
    vecs.push_back('{1'b0, 3'b000, z});
    for (int e = 3; e <= 7; e++) vecs.push_back('{1'b0, 3'b010, z});
    vecs.push_back('{1'b0, 3'b010, p1});
    vecs.push_back('{1'b0, 3'b010, h1});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].btn);
      chk("vec_level",   a_level,   vecs[i].exp.lvl);
      chk("vec_press",   a_press,   vecs[i].exp.prs);
      chk("vec_release", a_release, vecs[i].exp.rel);
      chk("vec_pulse",   a_pulse,   vecs[i].exp.pls);
    end

    // Auto-repeat on channel 2, release accepted 6 edges after the button falls.
    step(1'b1, 3'b000);
    for (int e = 1; e <= 40; e++) begin
      step(1'b0, (e <= 24) ? 3'b100 : 3'b000);
      chk("rpt_pulse", a_pulse, (e inside {6, 16, 19, 22, 25, 28}) ? 3'b100 : 3'b000);
      chk("rpt_press", a_press, (e == 6) ? 3'b100 : 3'b000);
      chk("rpt_release", a_release, (e == 30) ? 3'b100 : 3'b000);
      chk("rpt_level", a_level, (e >= 6 && e < 30) ? 3'b100 : 3'b000);
    end

    // Release acceptance lands on the repeat terminal count at edge 31.
    step(1'b1, 3'b000);
    for (int e = 1; e <= 58; e++) begin
      step(1'b0, (e <= 25 || e > 40) ? 3'b100 : 3'b000);
      chk("col_release", a_release, (e == 31) ? 3'b100 : 3'b000);
      chk("col_pulse", a_pulse,
          (e inside {6, 16, 19, 22, 25, 28, 46, 56}) ? 3'b100 : 3'b000);
      chk("col_level", a_level, ((e >= 6 && e < 31) || e >= 46) ? 3'b100 : 3'b000);
    end

    // Reset during REPEAT with the button held; press re-fires 6 edges later.
    step(1'b1, 3'b000);
    for (int e = 1; e <= 40; e++) begin
      step((e == 20) ? 1'b1 : 1'b0, 3'b100);
      if (e == 20) begin
        chk("rst_level", a_level, 3'b000);
        chk("rst_press", a_press, 3'b000);
        chk("rst_release", a_release, 3'b000);
        chk("rst_pulse", a_pulse, 3'b000);
      end
      chk("rst_press_t", a_press, (e == 6 || e == 26) ? 3'b100 : 3'b000);
      chk("rst_pulse_t", a_pulse,
          (e inside {6, 16, 19, 26, 36, 39}) ? 3'b100 : 3'b000);
    end

    // Channels 0 and 2 together; the no-repeat instance emits only the press pulse.
    step(1'b1, 3'b000);
    for (int e = 1; e <= 40; e++) begin
      step(1'b0, (e <= 30) ? 3'b101 : 3'b000);
      if (e <= 30) begin
        chk("mc_a_press", a_press, (e == 6) ? 3'b101 : 3'b000);
        chk("mc_a_pulse", a_pulse,
            (e inside {6, 16, 19, 22, 25, 28}) ? 3'b101 : 3'b000);
        chk("mc_b_level", b_level, (e >= 6) ? 3'b101 : 3'b000);
      end
      chk("mc_b_pulse", b_pulse, (e == 6) ? 3'b101 : 3'b000);
      chk("mc_b_release", b_release, (e == 36) ? 3'b101 : 3'b000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
